// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI deframer.
package nrzi_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Frame flag in reception order. It reads the same in both directions,
  // so the shift direction of the window does not matter for detection.
  localparam logic [7:0] NRZI_FLAG = 8'b1000_0001;

  // Zero-run length after which the transmitter inserts a one.
  localparam int STUFF_RUN_DFLT = 5;

endpackage

// File: rtl/nrzi_flag_window.sv
// Raw 8-bit receive window with per-bit valid mask and flag detection.
// A bit reaches the data path only after it has aged through the whole
// window, which guarantees that the flag bits never leak into payload.
module nrzi_flag_window
  import nrzi_pkg::*;
(
  input  logic refclk,
  input  logic reset_n,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic mask_clr,
  output logic exit_bit,
  output logic exit_vld,
  output logic flag_hit
);

  logic [7:0] win;
  logic [7:0] mask;
  logic [7:0] win_nxt;

  assign win_nxt  = {win[6:0], bit_in};
  assign flag_hit = bit_valid && (win_nxt == NRZI_FLAG);
  assign exit_bit = win[7];
  assign exit_vld = mask[7];

  // Shift window and mask on each strobe; a flag or a drop to HUNT empties the mask.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      win  <= '0;
      mask <= '0;
    end else if (bit_valid) begin
      win  <= win_nxt;
      mask <= (flag_hit || mask_clr) ? 8'h00 : {mask[6:0], 1'b1};
    end
  end

endmodule

// File: rtl/nrzi_deframer.sv
// NRZI deframer: flag sync, destuffing, LSB-first byte assembly, framing errors.
module nrzi_deframer
  import nrzi_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int STUFF_RUN = STUFF_RUN_DFLT
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       sof,
  output logic       eof,
  output logic       err,
  output logic       locked
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int ZW = $clog2(STUFF_RUN + 1);

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [BW-1:0] byte_cnt, byte_cnt_nxt;
  logic [ZW-1:0] zrun, zrun_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          dv_nxt, sof_nxt, eof_nxt, err_nxt;
  logic          to_hunt, mask_clr;
  logic          exit_bit, exit_vld, flag_hit;

  nrzi_flag_window u_win (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .mask_clr  (mask_clr),
    .exit_bit  (exit_bit),
    .exit_vld  (exit_vld),
    .flag_hit  (flag_hit)
  );

  // FSM state register.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_nxt;
  end

  // Next state and datapath: exiting bit is handled first, then the flag action.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    zrun_nxt     = zrun;
    shreg_nxt    = shreg;
    data_nxt     = data;
    dv_nxt       = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    err_nxt      = 1'b0;
    to_hunt      = 1'b0;
    mask_clr     = 1'b0;
    if (bit_valid) begin
      if (state == LOCKED && exit_vld) begin
        if (zrun == ZW'(STUFF_RUN)) begin
          // After a full zero run the next bit must be the inserted one.
          if (exit_bit) zrun_nxt = '0;
          else begin
            err_nxt = 1'b1;
            to_hunt = 1'b1;
          end
        end else begin
          zrun_nxt = exit_bit ? '0 : zrun + ZW'(1);
          shreg_nxt[bit_cnt] = exit_bit;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == BW'(MAX_LEN)) begin
              err_nxt = 1'b1;
              to_hunt = 1'b1;
            end else begin
              data_nxt     = shreg_nxt;
              dv_nxt       = 1'b1;
              sof_nxt      = (byte_cnt == '0);
              byte_cnt_nxt = byte_cnt + BW'(1);
              bit_cnt_nxt  = '0;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      if (to_hunt) begin
        state_nxt    = HUNT;
        bit_cnt_nxt  = '0;
        byte_cnt_nxt = '0;
        zrun_nxt     = '0;
        mask_clr     = 1'b1;
      end
      if (flag_hit) begin
        // Closing flag: clean end only if byte-aligned and something arrived.
        if (state_nxt == LOCKED) begin
          if (bit_cnt_nxt == '0 && byte_cnt_nxt != '0) eof_nxt = 1'b1;
          else if (bit_cnt_nxt != '0)                  err_nxt = 1'b1;
        end
        state_nxt    = LOCKED;
        bit_cnt_nxt  = '0;
        byte_cnt_nxt = '0;
        zrun_nxt     = '0;
      end
    end
  end

  // Datapath registers and registered output pulses.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      zrun       <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      err        <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      zrun       <= zrun_nxt;
      shreg      <= shreg_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      sof        <= sof_nxt;
      eof        <= eof_nxt;
      err        <= err_nxt;
    end
  end

  // Output decode of the state register.
  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_nrzi_deframer.sv
// Directed bench with event scoreboard for the NRZI deframer.
module tb_nrzi_deframer;

  logic refclk = 1'b0;
  logic reset_n = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;

  logic [7:0] data0, data4;
  logic dv0, sof0, eof0, err0, lck0;
  logic dv4, sof4, eof4, err4, lck4;

  always #5 refclk = ~refclk;

  nrzi_deframer #(.MAX_LEN(64), .STUFF_RUN(5)) u_dut (
    .refclk(refclk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .data(data0), .data_valid(dv0), .sof(sof0), .eof(eof0), .err(err0), .locked(lck0)
  );

  nrzi_deframer #(.MAX_LEN(4), .STUFF_RUN(5)) u_dut4 (
    .refclk(refclk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .data(data4), .data_valid(dv4), .sof(sof4), .eof(eof4), .err(err4), .locked(lck4)
  );

  typedef struct packed {
    logic       dv;
    logic       sof;
    logic [7:0] data;
    logic       eof;
    logic       err;
  } ev_t;

  ev_t q0[$];
  ev_t q4[$];
  int checks = 0;
  int errors = 0;

  function automatic ev_t mkev(logic dv, logic s, logic [7:0] d, logic e, logic r);
    return {dv, s, d, e, r};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send n bits of v, v[0] first, one strobe every third cycle.
  task automatic send_bits(logic [31:0] v, int n);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge refclk);
      bit_in    = v[i];
      bit_valid = 1'b1;
      @(negedge refclk);
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_flag();
    send_bits(32'h81, 8);
  endtask

  task automatic drain(string tag);
    repeat (3) @(negedge refclk);
    chk({tag, "_q0_left"}, 16'(q0.size()), 16'd0);
    chk({tag, "_q4_left"}, 16'(q4.size()), 16'd0);
  endtask

  // Scoreboard: every output event is matched against the next expected one.
  always @(negedge refclk) begin
    ev_t ev;
    if (reset_n) begin
      if (dv0 || eof0 || err0) begin
        ev = {dv0, sof0, (dv0 ? data0 : 8'h00), eof0, err0};
        if (q0.size() == 0) chk("dut64_unexpected_event", 16'(ev), 16'd0);
        else                chk("dut64_event", 16'(ev), 16'(q0.pop_front()));
      end
      if (dv4 || eof4 || err4) begin
        ev = {dv4, sof4, (dv4 ? data4 : 8'h00), eof4, err4};
        if (q4.size() == 0) chk("dut4_unexpected_event", 16'(ev), 16'd0);
        else                chk("dut4_event", 16'(ev), 16'(q4.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random strobes: everything stays zero.
    for (int i = 0; i < 12; i++) begin
      @(negedge refclk);
      chk("reset_dut64", {4'h0, data0, dv0, sof0, eof0, err0}, 16'd0);
      chk("reset_dut4",  {4'h0, data4, dv4, sof4, eof4, err4}, 16'd0);
      chk("reset_locked", {14'd0, lck0, lck4}, 16'd0);
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
    end
    bit_valid = 1'b0;
    @(negedge refclk);
    reset_n = 1'b1;
    @(negedge refclk);

    // Lock: not yet after 7 flag bits, locked right after the 8th.
    send_bits(32'h01, 7);
    chk("lock_early", {14'd0, lck0, lck4}, 16'd0);
    send_bits(32'h1, 1);
    chk("lock_after_flag", {14'd0, lck0, lck4}, 16'h3);

    // Two-byte frame; last byte and eof share one cycle.
    q0.push_back(mkev(1, 1, 8'hA5, 0, 0)); q4.push_back(mkev(1, 1, 8'hA5, 0, 0));
    q0.push_back(mkev(1, 0, 8'h3C, 1, 0)); q4.push_back(mkev(1, 0, 8'h3C, 1, 0));
    send_bits(32'hA5, 8);
    send_bits(32'h3C, 8);
    send_flag();
    drain("two_bytes");
    chk("data_holds", 16'(data0), 16'h3C);

    // Stuffed zero byte: 0,0,0,0,0,(1),0,0,0.
    q0.push_back(mkev(1, 1, 8'h00, 1, 0)); q4.push_back(mkev(1, 1, 8'h00, 1, 0));
    send_flag();
    send_bits(32'h020, 9);
    send_flag();
    drain("stuffed_zero");
    chk("stuffed_locked", {14'd0, lck0, lck4}, 16'h3);

    // Stuffing violation: 1,1,0 then seven zeros, pushed through with ones.
    q0.push_back(mkev(0, 0, 8'h00, 0, 1)); q4.push_back(mkev(0, 0, 8'h00, 0, 1));
    send_flag();
    send_bits(32'h003, 10);
    send_bits(32'hFF, 8);
    drain("stuff_violation");
    chk("violation_unlocked", {14'd0, lck0, lck4}, 16'd0);

    // Misaligned close: 0xFF plus four ones, then a normal 0x11 frame.
    q0.push_back(mkev(1, 1, 8'hFF, 0, 0)); q4.push_back(mkev(1, 1, 8'hFF, 0, 0));
    q0.push_back(mkev(0, 0, 8'h00, 0, 1)); q4.push_back(mkev(0, 0, 8'h00, 0, 1));
    q0.push_back(mkev(1, 1, 8'h11, 1, 0)); q4.push_back(mkev(1, 1, 8'h11, 1, 0));
    send_flag();
    send_bits(32'hFFF, 12);
    send_flag();
    chk("misaligned_locked", {14'd0, lck0, lck4}, 16'h3);
    send_bits(32'h11, 8);
    send_flag();
    drain("misaligned");

    // Overlength: the MAX_LEN=4 instance errors on byte 5, the other takes all five.
    q0.push_back(mkev(1, 1, 8'h11, 0, 0)); q4.push_back(mkev(1, 1, 8'h11, 0, 0));
    q0.push_back(mkev(1, 0, 8'h22, 0, 0)); q4.push_back(mkev(1, 0, 8'h22, 0, 0));
    q0.push_back(mkev(1, 0, 8'h33, 0, 0)); q4.push_back(mkev(1, 0, 8'h33, 0, 0));
    q0.push_back(mkev(1, 0, 8'h44, 0, 0)); q4.push_back(mkev(1, 0, 8'h44, 0, 0));
    q0.push_back(mkev(1, 0, 8'h55, 0, 0)); q4.push_back(mkev(0, 0, 8'h00, 0, 1));
    send_flag();
    send_bits(32'h11, 8);
    send_bits(32'h22, 8);
    send_bits(32'h33, 8);
    send_bits(32'h44, 8);
    send_bits(32'h55, 8);
    send_bits(32'hFF, 8);
    drain("overlength");
    chk("overlength_locked", {14'd0, lck0, lck4}, 16'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrzi_deframer.md
# nrzi_deframer

Consumes the recovered bit stream of the NRZI decoder: one data bit per `bit_valid` strobe, roughly one strobe every 8 `refclk` cycles. Detects the frame flag, removes transmitter-inserted stuff bits and assembles bytes LSB-first. Emits bytes with start/end-of-frame markers and reports framing errors. Sits directly downstream of the NRZI decoder and upstream of the packet buffer.

## Interface
- `MAX_LEN`, 64: maximum payload bytes per frame. Must be ≥1.
- `STUFF_RUN`, 5: zero-run length after which the transmitter inserts a `1`.
- `refclk  in  1`: sole clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `bit_valid  in  1`: one-cycle strobe, synchronous to `refclk`; a new bit is present on `bit_in`.
- `bit_in  in  1`: NRZI-decoded data bit, sampled only when `bit_valid`=1.
- `data  out  8`: assembled byte, LSB received first. Holds its value between strobes.
- `data_valid  out  1`: one-cycle pulse; `data` is new.
- `sof  out  1`: qualifies `data_valid`; the byte is the first of its frame.
- `eof  out  1`: one-cycle pulse; the closing flag of a non-empty, byte-aligned frame was received.
- `err  out  1`: one-cycle pulse on any framing error.
- `locked  out  1`: level, high while flag-synchronised.

## Operation
- Flag = `10000001`, bits in reception order. The flag is the only legal run of more than `STUFF_RUN` zeros.
- Raw window: an 8-bit shift register plus an 8-bit valid mask. Each strobe shifts `bit_in` in. The bit shifted out is the "exiting bit"; it goes to the data path only if its mask bit is set, `locked`=1, and no error has occurred on this strobe.
- Flag detect: the window, including the new bit, equals the flag. Then: clear the whole mask, clear `bit_cnt` and `zrun`, and set `locked`.
- Destuffing on the exiting bit, using `zrun` (consecutive zeros counted in the data path):
  - `zrun`<`STUFF_RUN`, bit 0: append 0, `zrun`++.
  - bit 1 with `zrun`<`STUFF_RUN`: append 1, `zrun`=0.
  - `zrun`==`STUFF_RUN`, bit 1: discard it (stuff bit), `zrun`=0.
  - `zrun`==`STUFF_RUN`, bit 0: stuffing violation. Pulse `err`, go to HUNT.
- Byte assembly: the appended bit goes into `shreg[bit_cnt]`. On `bit_cnt`==7: `data`←byte, pulse `data_valid`, `sof`=(`byte_cnt`==0), `byte_cnt`++, `bit_cnt`=0.
- States:
  - HUNT: `locked`=0. The window runs, the data path is idle. Flag detect goes to LOCKED.
  - LOCKED: `locked`=1.
    - A flag with `bit_cnt`==0 and `byte_cnt`>0: pulse `eof`, `byte_cnt`=0.
    - A flag with `bit_cnt`≠0: pulse `err`, no `eof`, `byte_cnt`=0, stay LOCKED.
    - A flag with nothing received: idle, no pulse.
    - A byte completing with `byte_cnt`==`MAX_LEN` already reached: pulse `err`, go to HUNT, no `data_valid`.
- Same strobe: the exiting bit is processed first, then the flag action. One strobe can therefore produce `data_valid` and `eof` together, meaning that byte is the last of the frame.
- Transitions to HUNT clear `bit_cnt`, `byte_cnt`, `zrun` and the mask.

## Timing
- Reset (`reset_n`=0, async): all state and all outputs 0; state HUNT.
- Every output is registered. Pulses occur in the cycle after the `bit_valid` strobe that caused them and last exactly one cycle.
- Latency: a bit reaches the assembler 8 strobes after arrival. `data_valid` follows 1 cycle after the strobe that supplied the byte's 8th data bit.
- With no `bit_valid`, all state holds.
- Reset asserted mid-frame: the partial byte is dropped and no `eof` is emitted.

## Structure
- Package `nrzi_pkg`:
  - the state enum `{HUNT, LOCKED}`;
  - `NRZI_FLAG = 8'b1000_0001`;
  - `STUFF_RUN` default.
- Sub-module `nrzi_flag_window`: raw window, valid mask and flag detect. Outputs the exiting bit, its valid and the flag hit.
- Top: destuffer, byte assembler, counters and FSM.
- `byte_cnt` width is `$clog2(MAX_LEN+1)`.

## Test plan
- Reset: hold `reset_n`=0 with random strobes. All outputs stay 0 and `locked`=0. Release, then send a flag: `locked`=1 one cycle after the flag's last strobe.
- Send flag, `0xA5`, `0x3C`, flag. Expect `data_valid`×2 with `data`=`0xA5` (`sof`=1) then `0x3C` (`sof`=0), then `eof` one pulse, `err` never.
- Send flag, stuffed `0x00` (bits 0,0,0,0,0,1,0,0,0), flag. Expect a single byte `0x00`, then `eof`.
- Send flag, 3 data bits, then `0000000`, no flag match. Expect an `err` pulse, `locked`→0, no `data_valid`.
- Send flag, 12 data bits (`0xFF` + 4 ones), flag. Expect `data`=`0xFF`, then `err`, no `eof`, `locked` stays 1. A following frame of `0x11` then flag is received normally.
- With `MAX_LEN`=4, send flag and 5 bytes. Expect 4 `data_valid`, then `err` on the 5th byte, `locked`→0, no `eof`.
